// File: rtl/gpu_ram_pkg.sv
// ---------------------------------------------------------------------------
// gpu_ram_pkg
// Shared definitions for the GPU RAM arbiter slice:
//   - default address width / addressable-memory size / RAM read latency
//   - requester source encodings (Z80 bridge vs secondary engine)
//   - read-tag structure carried down the latency-matched tag pipe
//   - default data returned for out-of-range reads
// ---------------------------------------------------------------------------
package gpu_ram_pkg;

    localparam int ADDR_W_DEF        = 20;
    localparam int MEM_SIZE_BITS_DEF = 15;
    localparam int RAM_RD_LAT_DEF    = 2;

    localparam logic [7:0] OOR_DATA_DEF = 8'hFF;

    // Requester identity stored in each in-flight read tag.
    localparam logic SRC_Z80 = 1'b0;
    localparam logic SRC_SEC = 1'b1;

    typedef struct packed {
        logic valid;   // a read response is owed for this slot
        logic src;     // SRC_Z80 or SRC_SEC
        logic oor;     // address was out of range: answer with OOR data
    } ram_tag_t;

    localparam ram_tag_t TAG_IDLE = '{valid: 1'b0, src: SRC_Z80, oor: 1'b0};

    // True when a tag carries a live read belonging to the given requester.
    function automatic logic tag_hits(input ram_tag_t tag, input logic src);
        return tag.valid && (tag.src == src);
    endfunction

endpackage

// File: rtl/gpu_ram_tag_pipe.sv
// ---------------------------------------------------------------------------
// gpu_ram_tag_pipe
// Fixed-depth shift register of read tags. A new tag enters stage 0 every
// cycle (an idle tag when nothing was read) and emerges from the last stage
// DEPTH cycles later, lined up with the RAM read data.
// Ports:
//   i_clk  - clock, rising edge
//   i_clr  - synchronous clear of every stage
//   i_tag  - tag for the access issued this cycle
//   o_tag  - tag leaving the final stage
// ---------------------------------------------------------------------------
module gpu_ram_tag_pipe
    import gpu_ram_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic     i_clk,
    input  logic     i_clr,
    input  ram_tag_t i_tag,
    output ram_tag_t o_tag
);

    ram_tag_t r_stage [DEPTH];

    // Shift tags one stage per cycle; clear drops every in-flight read.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= TAG_IDLE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/gpu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// gpu_ram_arbiter
// Shares the single GPU RAM port between the Z80 bridge (one-cycle write/read
// pulses, highest priority, never stalled) and a secondary engine (level
// request with combinational ack). One access is issued per cycle; the RAM
// controls are registered so the access appears on ram_* one cycle after
// arbitration. Reads are tracked by a tag pipe of RAM_RD_LAT+1 stages so the
// returning data is routed to the requester that issued it. Addresses at or
// beyond 2**MEM_SIZE_BITS never reach the RAM: writes are dropped, reads are
// answered with OOR_DATA at the normal latency.
// Ports:
//   GPU_CLK, reset                 - clock and synchronous active-high reset
//   z80_wr_ena/z80_rd_req          - Z80 access pulses (write wins if both)
//   z80_addr/z80_wdata             - Z80 address / write data
//   z80_rdata/z80_rd_rdy           - Z80 read data and its ready pulse
//   z80_collision                  - sticky flag: write and read pulsed together
//   sec_req/sec_we/sec_addr/sec_wdata - secondary request (held until ack)
//   sec_ack                        - secondary request accepted this cycle
//   sec_rdata/sec_rd_valid         - secondary read data and its valid pulse
//   ram_addr/ram_wdata/ram_wr_ena/ram_rd_ena - registered RAM controls
//   ram_rdata                      - RAM data, RAM_RD_LAT after ram_rd_ena
// ---------------------------------------------------------------------------
module gpu_ram_arbiter
    import gpu_ram_pkg::*;
#(
    parameter int         ADDR_W        = ADDR_W_DEF,
    parameter int         MEM_SIZE_BITS = MEM_SIZE_BITS_DEF,
    parameter int         RAM_RD_LAT    = RAM_RD_LAT_DEF,
    parameter logic [7:0] OOR_DATA      = OOR_DATA_DEF
) (
    input  logic              GPU_CLK,
    input  logic              reset,
    input  logic              z80_wr_ena,
    input  logic              z80_rd_req,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [7:0]        z80_wdata,
    output logic [7:0]        z80_rdata,
    output logic              z80_rd_rdy,
    output logic              z80_collision,
    input  logic              sec_req,
    input  logic              sec_we,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [7:0]        sec_wdata,
    output logic              sec_ack,
    output logic [7:0]        sec_rdata,
    output logic              sec_rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wr_ena,
    output logic              ram_rd_ena,
    input  logic [7:0]        ram_rdata
);

    localparam int TAG_DEPTH = RAM_RD_LAT + 1;

    // Any bit at or above MEM_SIZE_BITS set means the address is beyond memory.
    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr);
        return (addr >> MEM_SIZE_BITS) != {ADDR_W{1'b0}};
    endfunction

    logic              w_sel_valid;
    logic              w_sel_we;
    logic              w_sel_src;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_wdata;
    logic              w_sel_oor;
    logic              w_issue_wr;
    logic              w_issue_rd;
    ram_tag_t          w_tag_in;
    ram_tag_t          w_tag_out;
    logic [7:0]        w_resp_data;
    logic              w_z80_resp;
    logic              w_sec_resp;

    // Fixed-priority arbitration: Z80 pulse first, then held secondary request.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_src   = SRC_Z80;
        w_sel_addr  = {ADDR_W{1'b0}};
        w_sel_wdata = 8'h00;
        sec_ack     = 1'b0;
        if (reset) begin
            w_sel_valid = 1'b0;
        end else if (z80_wr_ena || z80_rd_req) begin
            // On a collision the write wins and the read is dropped.
            w_sel_valid = 1'b1;
            w_sel_we    = z80_wr_ena;
            w_sel_src   = SRC_Z80;
            w_sel_addr  = z80_addr;
            w_sel_wdata = z80_wdata;
        end else if (sec_req) begin
            w_sel_valid = 1'b1;
            w_sel_we    = sec_we;
            w_sel_src   = SRC_SEC;
            w_sel_addr  = sec_addr;
            w_sel_wdata = sec_wdata;
            sec_ack     = 1'b1;
        end else begin
            w_sel_valid = 1'b0;
        end
    end

    // Range gating and tag build: out-of-range reads still take a tag slot.
    always_comb begin
        w_sel_oor        = addr_oor(w_sel_addr);
        w_issue_wr       = w_sel_valid && w_sel_we && !w_sel_oor;
        w_issue_rd       = w_sel_valid && !w_sel_we && !w_sel_oor;
        w_tag_in         = TAG_IDLE;
        w_tag_in.valid   = w_sel_valid && !w_sel_we;
        w_tag_in.src     = w_sel_src;
        w_tag_in.oor     = w_sel_oor;
    end

    gpu_ram_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .i_clk (GPU_CLK),
        .i_clr (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // Response data source: the RAM, or the fixed value for out-of-range reads.
    always_comb begin
        if (w_tag_out.oor) begin
            w_resp_data = OOR_DATA;
        end else begin
            w_resp_data = ram_rdata;
        end
        w_z80_resp = tag_hits(w_tag_out, SRC_Z80);
        w_sec_resp = tag_hits(w_tag_out, SRC_SEC);
    end

    // Registered RAM port: enables last one cycle, address/data hold when idle.
    always_ff @(posedge GPU_CLK) begin
        if (reset) begin
            ram_addr   <= {ADDR_W{1'b0}};
            ram_wdata  <= 8'h00;
            ram_wr_ena <= 1'b0;
            ram_rd_ena <= 1'b0;
        end else begin
            ram_wr_ena <= w_issue_wr;
            ram_rd_ena <= w_issue_rd;
            if (w_issue_wr || w_issue_rd) begin
                ram_addr <= w_sel_addr;
            end
            if (w_issue_wr) begin
                ram_wdata <= w_sel_wdata;
            end
        end
    end

    // Read-data return: route by tag source; data holds until the next response.
    always_ff @(posedge GPU_CLK) begin
        if (reset) begin
            z80_rdata    <= 8'h00;
            z80_rd_rdy   <= 1'b0;
            sec_rdata    <= 8'h00;
            sec_rd_valid <= 1'b0;
        end else begin
            z80_rd_rdy   <= w_z80_resp;
            sec_rd_valid <= w_sec_resp;
            if (w_z80_resp) begin
                z80_rdata <= w_resp_data;
            end
            if (w_sec_resp) begin
                sec_rdata <= w_resp_data;
            end
        end
    end

    // Sticky collision flag, cleared only by reset.
    always_ff @(posedge GPU_CLK) begin
        if (reset) begin
            z80_collision <= 1'b0;
        end else if (z80_wr_ena && z80_rd_req) begin
            z80_collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpu_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gpu_ram_arbiter
// Random Z80 pulses, secondary requests and occasional resets drive the
// arbiter, which is attached to a behavioural RAM with RAM_RD_LAT latency.
// A transaction-level reference model predicts, per cycle, the RAM port
// outputs, the ack and the read responses: it applies accesses to its own
// memory in issue order and schedules each read answer at issue+2+LAT.
// ---------------------------------------------------------------------------
module tb_gpu_ram_arbiter;

    localparam int LAT    = 2;
    localparam int AW     = 20;
    localparam int MSB    = 15;
    localparam int MEMSZ  = 32768;
    localparam int NCYC   = 4000;
    localparam int RSZ    = NCYC + LAT + 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          z80_wr_ena, z80_rd_req;
    logic [AW-1:0] z80_addr;
    logic [7:0]    z80_wdata, z80_rdata;
    logic          z80_rd_rdy, z80_collision;
    logic          sec_req, sec_we, sec_ack, sec_rd_valid;
    logic [AW-1:0] sec_addr;
    logic [7:0]    sec_wdata, sec_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, ram_rdata;
    logic          ram_wr_ena, ram_rd_ena;

    always #5 clk = ~clk;

    gpu_ram_arbiter dut (
        .GPU_CLK       (clk),
        .reset         (reset),
        .z80_wr_ena    (z80_wr_ena),
        .z80_rd_req    (z80_rd_req),
        .z80_addr      (z80_addr),
        .z80_wdata     (z80_wdata),
        .z80_rdata     (z80_rdata),
        .z80_rd_rdy    (z80_rd_rdy),
        .z80_collision (z80_collision),
        .sec_req       (sec_req),
        .sec_we        (sec_we),
        .sec_addr      (sec_addr),
        .sec_wdata     (sec_wdata),
        .sec_ack       (sec_ack),
        .sec_rdata     (sec_rdata),
        .sec_rd_valid  (sec_rd_valid),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_wr_ena    (ram_wr_ena),
        .ram_rd_ena    (ram_rd_ena),
        .ram_rdata     (ram_rdata)
    );

    // ---------------- behavioural RAM ----------------
    logic [7:0] env_mem [MEMSZ];
    logic [7:0] rd_pipe [LAT];
    assign ram_rdata = rd_pipe[LAT-1];

    // RAM: write on ram_wr_ena, read data emerges LAT cycles after ram_rd_ena.
    always @(posedge clk) begin
        if (ram_wr_ena) env_mem[ram_addr[MSB-1:0]] <= ram_wdata;
        rd_pipe[0] <= ram_rd_ena ? env_mem[ram_addr[MSB-1:0]] : 8'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // ---------------- reference model ----------------
    logic [7:0]    ref_mem [MEMSZ];
    logic          rsp_z [RSZ];
    logic          rsp_s [RSZ];
    logic [7:0]    rsp_d [RSZ];
    logic          e_wr, e_rd, e_coll, e_zrdy, e_srdy, exp_ack;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_wdata, e_zdata, e_sdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the model by one cycle with the inputs currently driven.
    task automatic model_cycle(input int c, input logic rst);
        logic          valid, we, src, oor;
        logic [AW-1:0] a;
        logic [7:0]    d;
        exp_ack = 1'b0;
        if (rst) begin
            for (int t = c + 1; t < RSZ; t++) begin
                rsp_z[t] = 1'b0;
                rsp_s[t] = 1'b0;
            end
            e_wr = 1'b0; e_rd = 1'b0; e_coll = 1'b0;
            e_addr = '0; e_wdata = 8'h00;
            e_zrdy = 1'b0; e_srdy = 1'b0; e_zdata = 8'h00; e_sdata = 8'h00;
        end else begin
            valid = 1'b0; we = 1'b0; src = 1'b0; a = '0; d = 8'h00;
            if (z80_wr_ena || z80_rd_req) begin
                valid = 1'b1; src = 1'b0; we = z80_wr_ena; a = z80_addr; d = z80_wdata;
                if (z80_wr_ena && z80_rd_req) e_coll = 1'b1;
            end else if (sec_req) begin
                valid = 1'b1; src = 1'b1; we = sec_we; a = sec_addr; d = sec_wdata;
                exp_ack = 1'b1;
            end
            oor  = (a >= AW'(1 << MSB));
            e_wr = valid && we && !oor;
            e_rd = valid && !we && !oor;
            if (e_wr || e_rd) e_addr = a;
            if (e_wr) begin
                e_wdata = d;
                ref_mem[a[MSB-1:0]] = d;
            end
            if (valid && !we && (c + 2 + LAT < RSZ)) begin
                rsp_d[c+2+LAT] = oor ? 8'hFF : ref_mem[a[MSB-1:0]];
                if (src) rsp_s[c+2+LAT] = 1'b1;
                else     rsp_z[c+2+LAT] = 1'b1;
            end
            e_zrdy = rsp_z[c+1];
            e_srdy = rsp_s[c+1];
            if (rsp_z[c+1]) e_zdata = rsp_d[c+1];
            if (rsp_s[c+1]) e_sdata = rsp_d[c+1];
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = int'($urandom % 10);
        if (r < 7)      return AW'($urandom_range(0, 31));
        else if (r < 9) return AW'(32'h0000_8000 + ($urandom % 16));
        else            return AW'($urandom);
    endfunction

    logic last_ack;
    int   p;

    initial begin
        for (int i = 0; i < MEMSZ; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        for (int t = 0; t < RSZ; t++) begin
            rsp_z[t] = 1'b0; rsp_s[t] = 1'b0; rsp_d[t] = 8'h00;
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'h00;
        reset = 1'b1;
        z80_wr_ena = 1'b0; z80_rd_req = 1'b0; z80_addr = '0; z80_wdata = 8'h00;
        sec_req = 1'b0; sec_we = 1'b0; sec_addr = '0; sec_wdata = 8'h00;
        last_ack = 1'b0;
        model_cycle(0, 1'b1);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (c > 0) begin
                check_val("ram_wr_ena",    ram_wr_ena,    e_wr,    c);
                check_val("ram_rd_ena",    ram_rd_ena,    e_rd,    c);
                check_val("ram_addr",      ram_addr,      e_addr,  c);
                check_val("ram_wdata",     ram_wdata,     e_wdata, c);
                check_val("z80_rd_rdy",    z80_rd_rdy,    e_zrdy,  c);
                check_val("z80_rdata",     z80_rdata,     e_zdata, c);
                check_val("sec_rd_valid",  sec_rd_valid,  e_srdy,  c);
                check_val("sec_rdata",     sec_rdata,     e_sdata, c);
                check_val("z80_collision", z80_collision, e_coll,  c);
            end

            // Reset: start-up window plus rare random pulses mid-traffic.
            reset = (c < 3) || ($urandom % 400 == 0);

            // Z80 bridge pulses.
            z80_wr_ena = 1'b0; z80_rd_req = 1'b0;
            if ($urandom % 100 < 25) begin
                p = int'($urandom % 100);
                if (p < 50)      z80_rd_req = 1'b1;
                else if (p < 95) z80_wr_ena = 1'b1;
                else begin z80_wr_ena = 1'b1; z80_rd_req = 1'b1; end
                z80_addr  = rand_addr();
                z80_wdata = 8'($urandom);
            end

            // Secondary: hold until accepted, then maybe issue the next at once.
            if (last_ack) sec_req = 1'b0;
            if (!sec_req && ($urandom % 100 < 45)) begin
                sec_req   = 1'b1;
                sec_we    = 1'($urandom);
                sec_addr  = rand_addr();
                sec_wdata = 8'($urandom);
            end

            model_cycle(c, reset);
            #1;
            check_val("sec_ack", sec_ack, exp_ack, c);
            last_ack = exp_ack;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
